core_bus_arbiter: RTL and testbench
===================================

Name: core_bus_arbiter

Overview:
Merges the core's two AXI4-lite masters (instruction fetch and data) onto one AXI4-lite master port to the system interconnect.
- At most one transaction is in flight at a time.
- The data port has priority, with a starvation limiter that guarantees instruction fetch forward progress.
- Sits between the core's ifetch/data ports and the SoC bus.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while ifetch is waiting before ifetch is forced to win (range 1..15).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ifetch_bus  axi4lite.slave  interface  from core ifetch_port; uses aw/w/b/ar/r channels: awaddr[`ALEN], wdata[`XLEN], wstrb, bresp, araddr[`ALEN], rdata[`XLEN], rresp, plus valid/ready per channel
data_bus  axi4lite.slave  interface  from core data_port; same signal set
sys_bus  axi4lite.master  interface  to system interconnect
busy  output  1  a transaction is granted and not yet complete
grant_data  output  1  1 = current/last grant is data port, 0 = ifetch

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State IDLE; starve_cnt=0; busy=0; grant_data=0.
  - All sys_bus valids (awvalid, wvalid, arvalid) and readies (bready, rready) = 0.
  - All slave-side readies (awready, wready, arready) and valids (bvalid, rvalid) = 0.
- Request definition: a port requests when arvalid or awvalid is high. Within one port, read (arvalid) is chosen over write if both are high.
- States: IDLE, RD_ADDR, RD_RESP, WR_ADDR, WR_RESP.
- IDLE:
  - No forwarding happens.
  - If any request, latch the winner and operation type, then go to RD_ADDR or WR_ADDR.
  - Arbitration adds 1 cycle: the master-side valid first appears the cycle after the request is seen in IDLE.
- Winner selection:
  - Data wins, unless ifetch is requesting and starve_cnt==STARVE_LIMIT; then ifetch wins.
  - Only one requester: that requester wins.
- starve_cnt update, at grant only:
  - Data grant while ifetch requesting: +1, saturating at STARVE_LIMIT.
  - Data grant with ifetch idle: 0.
  - Ifetch grant: 0.
- RD_ADDR:
  - sys.araddr/arvalid come combinationally from the winner; winner arready = sys.arready.
  - Go to RD_RESP on the sys.arvalid & sys.arready handshake.
- RD_RESP:
  - Winner rvalid/rdata/rresp = sys values; sys.rready = winner rready.
  - Go to IDLE on the r handshake.
- WR_ADDR:
  - AW and W are forwarded independently, each with a done flag; a channel's valid is masked once its done flag is set.
  - AW and W may complete in the same or different cycles, in either order.
  - Go to WR_RESP when both are done, including the case where both handshake in the same cycle.
- WR_RESP: forward the b channel like the r channel; go to IDLE on the b handshake.
- Non-granted port, and both ports while in IDLE:
  - All readies and response valids = 0.
  - Its pending request stays pending; AXI rules require the master to hold it.
- Back-to-back operation: minimum 1 IDLE cycle between transactions. The outstanding response is always returned before the next address is issued, so ordering is strictly serialised.
- Response codes pass through unmodified. Addresses and data are not inspected.
- busy = state != IDLE. grant_data updates at grant and holds through IDLE.
- The core's pipeline flush does not abort a transaction: a granted transaction always runs to its response.
- Reset mid-transaction: next edge returns to IDLE and clears the done flags and starve_cnt. Master valids drop the cycle after the reset edge; the interconnect is reset together with the core.

Test Plan:
- Single ifetch read to 0x100, sys arready after 2 cycles, rdata 0xDEADBEEF -> ifetch sees arready once, then rvalid with 0xDEADBEEF; grant_data=0; back in IDLE 1 cycle after the r handshake.
- Simultaneous ifetch read and data read in IDLE -> data is serviced first, ifetch after; sys sees data's araddr first; starve_cnt=1.
- Data issues 6 back-to-back reads while ifetch continuously requests, STARVE_LIMIT=4 -> grants in order D,D,D,D,I,D,D; starve_cnt is 0 after the ifetch grant.
- Data write 0x2000/0x12345678 with wstrb 0xF, sys wready 3 cycles before awready -> W done first with its valid masked afterwards; WR_RESP entered only after AW; bresp=SLVERR (2) is returned unchanged to data.
- Data write with sys awready and wready asserted in the same cycle -> single-cycle WR_ADDR, then WR_RESP.
- rst asserted during RD_RESP -> next cycle state IDLE, busy=0, all sys valids/readies 0; after rst drops, a new ifetch read completes normally.

Source files
------------

// File: rtl/core_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_bus_arbiter
// Brief    : Serialising AXI4-lite arbiter, data-priority with ifetch anti-starvation
// Revision : 1.0
// ============================================================================
module core_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  // ifetch slave port
  input  logic [ADDR_W-1:0]   ifetch_awaddr,
  input  logic                ifetch_awvalid,
  output logic                ifetch_awready,
  input  logic [DATA_W-1:0]   ifetch_wdata,
  input  logic [DATA_W/8-1:0] ifetch_wstrb,
  input  logic                ifetch_wvalid,
  output logic                ifetch_wready,
  output logic [1:0]          ifetch_bresp,
  output logic                ifetch_bvalid,
  input  logic                ifetch_bready,
  input  logic [ADDR_W-1:0]   ifetch_araddr,
  input  logic                ifetch_arvalid,
  output logic                ifetch_arready,
  output logic [DATA_W-1:0]   ifetch_rdata,
  output logic [1:0]          ifetch_rresp,
  output logic                ifetch_rvalid,
  input  logic                ifetch_rready,
  // data slave port
  input  logic [ADDR_W-1:0]   data_awaddr,
  input  logic                data_awvalid,
  output logic                data_awready,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic                data_wvalid,
  output logic                data_wready,
  output logic [1:0]          data_bresp,
  output logic                data_bvalid,
  input  logic                data_bready,
  input  logic [ADDR_W-1:0]   data_araddr,
  input  logic                data_arvalid,
  output logic                data_arready,
  output logic [DATA_W-1:0]   data_rdata,
  output logic [1:0]          data_rresp,
  output logic                data_rvalid,
  input  logic                data_rready,
  // system master port
  output logic [ADDR_W-1:0]   sys_awaddr,
  output logic                sys_awvalid,
  input  logic                sys_awready,
  output logic [DATA_W-1:0]   sys_wdata,
  output logic [DATA_W/8-1:0] sys_wstrb,
  output logic                sys_wvalid,
  input  logic                sys_wready,
  input  logic [1:0]          sys_bresp,
  input  logic                sys_bvalid,
  output logic                sys_bready,
  output logic [ADDR_W-1:0]   sys_araddr,
  output logic                sys_arvalid,
  input  logic                sys_arready,
  input  logic [DATA_W-1:0]   sys_rdata,
  input  logic [1:0]          sys_rresp,
  input  logic                sys_rvalid,
  output logic                sys_rready,
  output logic                busy,
  output logic                grant_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_RESP = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  state_t     r_state;
  logic       r_sel_data;
  logic       r_aw_done;
  logic       r_w_done;
  logic [3:0] r_starve_cnt;

  logic w_if_req, w_d_req, w_pick_data, w_win_rd, w_sel_if;
  logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic w_st_ra, w_st_rr, w_st_wa, w_st_wr;

  assign w_if_req    = ifetch_arvalid | ifetch_awvalid;
  assign w_d_req     = data_arvalid | data_awvalid;
  // Data wins unless ifetch has waited through STARVE_LIMIT data grants
  assign w_pick_data = w_d_req & ~(w_if_req & (r_starve_cnt == c_starve_limit));
  assign w_win_rd    = w_pick_data ? data_arvalid : ifetch_arvalid;
  assign w_sel_if    = ~r_sel_data;

  assign w_st_ra = (r_state == S_RD_ADDR);
  assign w_st_rr = (r_state == S_RD_RESP);
  assign w_st_wa = (r_state == S_WR_ADDR);
  assign w_st_wr = (r_state == S_WR_RESP);

  // Master side: forward the latched winner, valids gated by phase
  assign sys_araddr  = r_sel_data ? data_araddr : ifetch_araddr;
  assign sys_arvalid = w_st_ra & (r_sel_data ? data_arvalid : ifetch_arvalid);
  assign sys_rready  = w_st_rr & (r_sel_data ? data_rready : ifetch_rready);
  assign sys_awaddr  = r_sel_data ? data_awaddr : ifetch_awaddr;
  assign sys_awvalid = w_st_wa & ~r_aw_done & (r_sel_data ? data_awvalid : ifetch_awvalid);
  assign sys_wdata   = r_sel_data ? data_wdata : ifetch_wdata;
  assign sys_wstrb   = r_sel_data ? data_wstrb : ifetch_wstrb;
  assign sys_wvalid  = w_st_wa & ~r_w_done & (r_sel_data ? data_wvalid : ifetch_wvalid);
  assign sys_bready  = w_st_wr & (r_sel_data ? data_bready : ifetch_bready);

  assign w_ar_hs = sys_arvalid & sys_arready;
  assign w_r_hs  = sys_rvalid & sys_rready;
  assign w_aw_hs = sys_awvalid & sys_awready;
  assign w_w_hs  = sys_wvalid & sys_wready;
  assign w_b_hs  = sys_bvalid & sys_bready;

  assign ifetch_arready = w_sel_if & w_st_ra & sys_arready;
  assign ifetch_rvalid  = w_sel_if & w_st_rr & sys_rvalid;
  assign ifetch_rdata   = sys_rdata;
  assign ifetch_rresp   = sys_rresp;
  assign ifetch_awready = w_sel_if & w_st_wa & ~r_aw_done & sys_awready;
  assign ifetch_wready  = w_sel_if & w_st_wa & ~r_w_done & sys_wready;
  assign ifetch_bvalid  = w_sel_if & w_st_wr & sys_bvalid;
  assign ifetch_bresp   = sys_bresp;

  assign data_arready = r_sel_data & w_st_ra & sys_arready;
  assign data_rvalid  = r_sel_data & w_st_rr & sys_rvalid;
  assign data_rdata   = sys_rdata;
  assign data_rresp   = sys_rresp;
  assign data_awready = r_sel_data & w_st_wa & ~r_aw_done & sys_awready;
  assign data_wready  = r_sel_data & w_st_wa & ~r_w_done & sys_wready;
  assign data_bvalid  = r_sel_data & w_st_wr & sys_bvalid;
  assign data_bresp   = sys_bresp;

  assign busy       = (r_state != S_IDLE);
  assign grant_data = r_sel_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sel_data   <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_starve_cnt <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_if_req | w_d_req) begin
            r_sel_data <= w_pick_data;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_state    <= w_win_rd ? S_RD_ADDR : S_WR_ADDR;
            if (w_pick_data && w_if_req)
              r_starve_cnt <= (r_starve_cnt == c_starve_limit) ? r_starve_cnt
                                                               : r_starve_cnt + 4'd1;
            else
              r_starve_cnt <= 4'd0;
          end
        end
        S_RD_ADDR: if (w_ar_hs) r_state <= S_RD_RESP;
        S_RD_RESP: if (w_r_hs)  r_state <= S_IDLE;
        S_WR_ADDR: begin
          // Both channels finishing in the same edge also counts as complete
          if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
            r_state   <= S_WR_RESP;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            r_aw_done <= r_aw_done | w_aw_hs;
            r_w_done  <= r_w_done | w_w_hs;
          end
        end
        S_WR_RESP: if (w_b_hs) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_bus_arbiter.sv
`default_nettype none
// Testbench for core_bus_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_core_bus_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] ifetch_awaddr, ifetch_wdata, ifetch_araddr, ifetch_rdata;
  logic [3:0]  ifetch_wstrb;
  logic        ifetch_awvalid, ifetch_awready, ifetch_wvalid, ifetch_wready;
  logic [1:0]  ifetch_bresp, ifetch_rresp;
  logic        ifetch_bvalid, ifetch_bready, ifetch_arvalid, ifetch_arready;
  logic        ifetch_rvalid, ifetch_rready;
  logic [31:0] data_awaddr, data_wdata, data_araddr, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_awvalid, data_awready, data_wvalid, data_wready;
  logic [1:0]  data_bresp, data_rresp;
  logic        data_bvalid, data_bready, data_arvalid, data_arready;
  logic        data_rvalid, data_rready;
  logic [31:0] sys_awaddr, sys_wdata, sys_araddr, sys_rdata;
  logic [3:0]  sys_wstrb;
  logic        sys_awvalid, sys_awready, sys_wvalid, sys_wready;
  logic [1:0]  sys_bresp, sys_rresp;
  logic        sys_bvalid, sys_bready, sys_arvalid, sys_arready;
  logic        sys_rvalid, sys_rready;
  logic        busy, grant_data;

  core_bus_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifetch_awaddr(ifetch_awaddr), .ifetch_awvalid(ifetch_awvalid), .ifetch_awready(ifetch_awready),
    .ifetch_wdata(ifetch_wdata), .ifetch_wstrb(ifetch_wstrb), .ifetch_wvalid(ifetch_wvalid),
    .ifetch_wready(ifetch_wready), .ifetch_bresp(ifetch_bresp), .ifetch_bvalid(ifetch_bvalid),
    .ifetch_bready(ifetch_bready), .ifetch_araddr(ifetch_araddr), .ifetch_arvalid(ifetch_arvalid),
    .ifetch_arready(ifetch_arready), .ifetch_rdata(ifetch_rdata), .ifetch_rresp(ifetch_rresp),
    .ifetch_rvalid(ifetch_rvalid), .ifetch_rready(ifetch_rready),
    .data_awaddr(data_awaddr), .data_awvalid(data_awvalid), .data_awready(data_awready),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_wvalid(data_wvalid),
    .data_wready(data_wready), .data_bresp(data_bresp), .data_bvalid(data_bvalid),
    .data_bready(data_bready), .data_araddr(data_araddr), .data_arvalid(data_arvalid),
    .data_arready(data_arready), .data_rdata(data_rdata), .data_rresp(data_rresp),
    .data_rvalid(data_rvalid), .data_rready(data_rready),
    .sys_awaddr(sys_awaddr), .sys_awvalid(sys_awvalid), .sys_awready(sys_awready),
    .sys_wdata(sys_wdata), .sys_wstrb(sys_wstrb), .sys_wvalid(sys_wvalid),
    .sys_wready(sys_wready), .sys_bresp(sys_bresp), .sys_bvalid(sys_bvalid),
    .sys_bready(sys_bready), .sys_araddr(sys_araddr), .sys_arvalid(sys_arvalid),
    .sys_arready(sys_arready), .sys_rdata(sys_rdata), .sys_rresp(sys_rresp),
    .sys_rvalid(sys_rvalid), .sys_rready(sys_rready),
    .busy(busy), .grant_data(grant_data)
  );

  int checks = 0;
  int errors = 0;

  // Per-port pending request (index 0 = ifetch, 1 = data) and master-side drive
  logic        p_req[2], p_wr[2];
  logic [31:0] p_addr[2], p_data[2];
  logic [3:0]  p_strb[2];
  logic        m_arv[2], m_awv[2], m_wv[2], m_rr[2], m_br[2];
  // Sampled slave-side outputs
  logic        s_arready[2], s_awready[2], s_wready[2], s_rvalid[2], s_bvalid[2];
  logic [31:0] s_rdata[2];
  logic [1:0]  s_rresp[2], s_bresp[2];

  int   m_starve;     // model: consecutive data grants while ifetch waited
  logic last_grant;   // model: grant_data value expected to hold in IDLE

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    ifetch_arvalid = m_arv[0]; ifetch_araddr = p_addr[0];
    ifetch_awvalid = m_awv[0]; ifetch_awaddr = p_addr[0];
    ifetch_wvalid  = m_wv[0];  ifetch_wdata  = p_data[0]; ifetch_wstrb = p_strb[0];
    ifetch_rready  = m_rr[0];  ifetch_bready = m_br[0];
    data_arvalid   = m_arv[1]; data_araddr   = p_addr[1];
    data_awvalid   = m_awv[1]; data_awaddr   = p_addr[1];
    data_wvalid    = m_wv[1];  data_wdata    = p_data[1]; data_wstrb = p_strb[1];
    data_rready    = m_rr[1];  data_bready   = m_br[1];
  endtask

  task automatic sample();
    s_arready[0] = ifetch_arready; s_awready[0] = ifetch_awready; s_wready[0] = ifetch_wready;
    s_rvalid[0]  = ifetch_rvalid;  s_bvalid[0]  = ifetch_bvalid;  s_rdata[0]  = ifetch_rdata;
    s_rresp[0]   = ifetch_rresp;   s_bresp[0]   = ifetch_bresp;
    s_arready[1] = data_arready;   s_awready[1] = data_awready;   s_wready[1] = data_wready;
    s_rvalid[1]  = data_rvalid;    s_bvalid[1]  = data_bvalid;    s_rdata[1]  = data_rdata;
    s_rresp[1]   = data_rresp;     s_bresp[1]   = data_bresp;
  endtask

  task automatic set_req(input int p, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] strb);
    p_req[p] = 1'b1; p_wr[p] = wr; p_addr[p] = addr; p_data[p] = wd; p_strb[p] = strb;
    m_arv[p] = ~wr; m_awv[p] = wr; m_wv[p] = wr;
  endtask

  // Ready is high from cycle d+1 onward (valid first appears at cycle 1); d<0 = random
  function automatic logic rdy(input int d, input int cyc);
    if (d < 0) return 1'($urandom_range(0, 1));
    return (cyc >= d + 1);
  endfunction

  // Runs one granted transaction from IDLE to its response, acting as the slave.
  task automatic run_txn(input int ar_d, input int aw_d, input int w_d,
                         input logic [31:0] rsp_data, input logic [1:0] rsp_code);
    int   win, lose, n_ar, n_aw, n_w;
    logic rd, ar_done, aw_done, w_done, resp_on, fin, quiet, mask_ok, order_ok;
    win = (p_req[1] && !(p_req[0] && m_starve == LIMIT)) ? 1 : 0;
    if (win == 1) m_starve = p_req[0] ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
    else          m_starve = 0;
    lose = 1 - win;
    rd = ~p_wr[win];
    ar_done = 0; aw_done = 0; w_done = 0; resp_on = 0; fin = 0;
    quiet = 1; mask_ok = 1; order_ok = 1; n_ar = 0; n_aw = 0; n_w = 0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk);
      sys_arready = rdy(ar_d, cyc); sys_awready = rdy(aw_d, cyc); sys_wready = rdy(w_d, cyc);
      sys_rvalid = resp_on & rd; sys_bvalid = resp_on & ~rd;
      sys_rdata = rsp_data; sys_rresp = rsp_code; sys_bresp = rsp_code;
      for (int p = 0; p < 2; p++) begin
        m_rr[p] = 1'($urandom_range(0, 1)); m_br[p] = 1'($urandom_range(0, 1));
      end
      apply();
      #1;
      sample();
      if (cyc == 0) begin
        check("idle_busy", busy, 0);
        check("idle_no_issue", sys_arvalid | sys_awvalid, 0);
        check("grant_hold", grant_data, last_grant);
      end
      if (cyc == 1) begin
        check("issue_latency", rd ? sys_arvalid : sys_awvalid, 1);
        check("grant", grant_data, win[0]);
      end
      if (s_arready[lose] | s_awready[lose] | s_wready[lose] | s_rvalid[lose] | s_bvalid[lose])
        quiet = 0;
      n_ar += int'(s_arready[win]); n_aw += int'(s_awready[win]); n_w += int'(s_wready[win]);
      if ((aw_done && sys_awvalid) || (w_done && sys_wvalid)) mask_ok = 0;
      if (!resp_on && (sys_rready || sys_bready)) order_ok = 0;
      if (resp_on && (sys_arvalid || sys_awvalid || sys_wvalid)) order_ok = 0;
      if (rd && sys_arvalid && sys_arready) begin
        check("araddr", sys_araddr, p_addr[win]); ar_done = 1;
      end
      if (!rd && sys_awvalid && sys_awready) begin
        check("awaddr", sys_awaddr, p_addr[win]); aw_done = 1;
      end
      if (!rd && sys_wvalid && sys_wready) begin
        check("wdata", sys_wdata, p_data[win]);
        check("wstrb", sys_wstrb, p_strb[win]); w_done = 1;
      end
      if (resp_on && rd && sys_rready) begin
        check("rvalid", s_rvalid[win], 1);
        check("rdata", s_rdata[win], rsp_data);
        check("rresp", s_rresp[win], rsp_code); fin = 1;
      end
      if (resp_on && !rd && sys_bready) begin
        check("bvalid", s_bvalid[win], 1);
        check("bresp", s_bresp[win], rsp_code); fin = 1;
      end
      if (!resp_on && (ar_done || (aw_done && w_done))) begin
        resp_on = 1; m_arv[win] = 0; m_awv[win] = 0; m_wv[win] = 0;
      end
    end
    check("txn_timeout", fin, 1);
    check("loser_quiet", quiet, 1);
    check("done_mask", mask_ok, 1);
    check("phase_order", order_ok, 1);
    if (rd) check("arready_once", n_ar, 1);
    else    check("aw_w_ready_once", {n_aw[15:0], n_w[15:0]}, {16'd1, 16'd1});
    p_req[win] = 0;
    last_grant = win[0];
  endtask

  logic [6:0] exp_order;

  initial begin
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 0; p_wr[p] = 0; p_addr[p] = 0; p_data[p] = 0; p_strb[p] = 0;
      m_arv[p] = 0; m_awv[p] = 0; m_wv[p] = 0; m_rr[p] = 0; m_br[p] = 0;
    end
    m_starve = 0; last_grant = 0;
    sys_arready = 0; sys_awready = 0; sys_wready = 0; sys_rvalid = 0; sys_bvalid = 0;
    sys_rdata = 0; sys_rresp = 0; sys_bresp = 0;
    apply();
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant_data, 0);
    check("rst_sys_valid", {sys_arvalid, sys_awvalid, sys_wvalid}, 0);
    check("rst_sys_ready", {sys_rready, sys_bready}, 0);
    check("rst_slave", {ifetch_arready, ifetch_awready, ifetch_wready, ifetch_rvalid,
                        ifetch_bvalid, data_arready, data_awready, data_wready,
                        data_rvalid, data_bvalid}, 0);
    rst = 0;

    // Single ifetch read, arready after 2 cycles
    set_req(0, 0, 32'h100, 0, 0);
    run_txn(2, -1, -1, 32'hDEADBEEF, 2'd0);

    // Simultaneous reads: data first, then ifetch
    set_req(0, 0, 32'h400, 0, 0);
    set_req(1, 0, 32'h500, 0, 0);
    run_txn(-1, -1, -1, 32'h11112222, 2'd0);
    check("simul_first_data", grant_data, 1);
    run_txn(-1, -1, -1, 32'h33334444, 2'd1);
    check("simul_then_ifetch", grant_data, 0);

    // Starvation limiter: D,D,D,D,I,D,D (bit k = grant k)
    exp_order = 7'b1101111;
    for (int k = 0; k < 7; k++) begin
      if (!p_req[1]) set_req(1, 0, 32'h1000 + 32'(k * 4), 0, 0);
      if (!p_req[0]) set_req(0, 0, 32'h600 + 32'(k * 4), 0, 0);
      run_txn(-1, -1, -1, $urandom, 2'($urandom_range(0, 3)));
      check("starve_order", grant_data, exp_order[k]);
    end
    run_txn(-1, -1, -1, $urandom, 2'd0);

    // Data write, W completes 3 cycles before AW, SLVERR back
    set_req(1, 1, 32'h2000, 32'h12345678, 4'hF);
    run_txn(-1, 3, 0, 32'h0, 2'd2);
    // Data write, AW and W in the same cycle
    set_req(1, 1, 32'h2004, 32'hCAFEF00D, 4'h3);
    run_txn(-1, 0, 0, 32'h0, 2'd0);

    // Randomized mixed traffic
    for (int t = 0; t < 40; t++) begin
      for (int p = 0; p < 2; p++)
        if (!p_req[p] && $urandom_range(0, 1) == 1)
          set_req(p, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
      if (!p_req[0] && !p_req[1]) set_req(t % 2, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
      run_txn(-1, -1, -1, $urandom, 2'($urandom_range(0, 3)));
    end
    while (p_req[0] || p_req[1]) run_txn(-1, -1, -1, $urandom, 2'd0);

    // Reset in the middle of a data read response
    set_req(1, 0, 32'h700, 0, 0);
    @(negedge clk);
    sys_arready = 1; sys_rvalid = 0; m_rr[0] = 0; m_rr[1] = 0;
    apply();
    @(negedge clk);
    apply();
    #1;
    check("mid_rst_ar", sys_arvalid, 1);
    @(negedge clk);
    m_arv[1] = 0; sys_rvalid = 1; sys_rdata = 32'h55AA55AA;
    apply();
    #1;
    check("mid_rst_busy_pre", busy, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant_data, 0);
    check("mid_rst_sys", {sys_arvalid, sys_awvalid, sys_wvalid, sys_rready, sys_bready}, 0);
    check("mid_rst_rvalid", data_rvalid, 0);
    rst = 0; sys_rvalid = 0;
    p_req[0] = 0; p_req[1] = 0; m_starve = 0; last_grant = 0;
    set_req(0, 0, 32'h800, 0, 0);
    run_txn(-1, -1, -1, 32'hFEEDFACE, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
